// File: rtl/esdi_pkg.sv
// rtl/esdi_pkg.sv - shared ESDI serial channel types, constants and parity helper
package esdi_pkg;

  localparam int ESDI_FRAME_BITS = 17;

  typedef enum logic [3:0] {
    IDLE,
    CMD_REQ,
    CMD_ACK,
    CHECK,
    DISPATCH,
    RSP_WAIT,
    ST_REQ,
    ST_SETUP,
    ST_ACK,
    DONE
  } esdi_state_e;

  // Parity bit that makes the 17-bit frame carry an odd number of ones.
  function automatic logic odd_parity(input logic [15:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/esdi_sync.sv
// rtl/esdi_sync.sv - N-flop synchronizer for asynchronous ESDI inputs
module esdi_sync #(
  parameter int N = 2
) (
  input  logic csr_aclk,
  input  logic csr_areset,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge csr_aclk or posedge csr_areset) begin
    if (csr_areset) ff <= '0;
    else            ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];

endmodule

// File: rtl/esdi_drive_cmd_responder.sv
// rtl/esdi_drive_cmd_responder.sv - drive-side ESDI serial command receiver and status transmitter
module esdi_drive_cmd_responder
  import esdi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_SETUP  = 6,
  parameter int BIT_TIMEOUT = 1_000_000
) (
  input  logic        csr_aclk,
  input  logic        csr_areset,
  input  logic        esdi_transfer_req,
  input  logic        esdi_command_data,
  output logic        esdi_transfer_ack,
  output logic        esdi_confstat_data,
  output logic        esdi_command_complete,
  output logic        esdi_attention,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [15:0] cmd_data,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [15:0] rsp_data,
  input  logic        rsp_last,
  input  logic        rsp_nodata,
  input  logic        rsp_attention,
  output logic        parity_err,
  output logic        frame_timeout
);

  localparam int TW = $clog2(BIT_TIMEOUT + 1);
  localparam int SW = $clog2(DATA_SETUP + 1);
  localparam logic [4:0] LAST_BIT = 5'(ESDI_FRAME_BITS - 1);

  esdi_state_e state, state_nxt;
  logic        req_s, data_s, req_q;
  logic [16:0] cmd_shift, st_word;
  logic [4:0]  bit_cnt;
  logic [SW-1:0] setup_cnt;
  logic [TW-1:0] to_cnt;
  logic        last_q, rsp_att_q;

  logic ack_nxt, confstat_nxt, cc_nxt, attention_nxt;
  logic cmd_valid_nxt, rsp_ready_nxt, parity_err_nxt, frame_timeout_nxt;

  esdi_sync #(.N(SYNC_STAGES)) u_sync_req (
    .csr_aclk(csr_aclk), .csr_areset(csr_areset), .d(esdi_transfer_req), .q(req_s)
  );
  esdi_sync #(.N(SYNC_STAGES)) u_sync_data (
    .csr_aclk(csr_aclk), .csr_areset(csr_areset), .d(esdi_command_data), .q(data_s)
  );

  logic req_edge, rsp_fire, parity_ok, timed_chk, timed_cnt, timeout;
  assign req_edge  = req_s ^ req_q;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign parity_ok = ^cmd_shift;
  assign timed_chk = (state == CMD_REQ) || (state == CMD_ACK) ||
                     (state == ST_REQ)  || (state == ST_ACK);
  // The setup hold keeps counting so a stalled host is still measured from its req edge.
  assign timed_cnt = timed_chk || (state == ST_SETUP);
  assign timeout   = timed_chk && (to_cnt == TW'(BIT_TIMEOUT));
  assign cmd_data  = cmd_shift[16:1];

  always_ff @(posedge csr_aclk or posedge csr_areset) begin
    if (csr_areset) begin
      state     <= IDLE;
      req_q     <= 1'b0;
      cmd_shift <= '0;
      st_word   <= '0;
      bit_cnt   <= '0;
      setup_cnt <= '0;
      to_cnt    <= '0;
      last_q    <= 1'b0;
      rsp_att_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      req_q  <= req_s;
      to_cnt <= (timed_cnt && !req_edge) ? to_cnt + 1'b1 : '0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (req_s) begin
            cmd_shift <= {cmd_shift[15:0], data_s};
            rsp_att_q <= 1'b0;
          end
        end
        CMD_REQ: if (req_s) cmd_shift <= {cmd_shift[15:0], data_s};
        CMD_ACK: if (!req_s && bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 1'b1;
        RSP_WAIT: if (rsp_fire) begin
          last_q  <= rsp_last;
          bit_cnt <= '0;
          st_word <= {rsp_data, odd_parity(rsp_data)};
          if (rsp_nodata || rsp_last) rsp_att_q <= rsp_attention;
        end
        ST_REQ:   setup_cnt <= '0;
        ST_SETUP: setup_cnt <= setup_cnt + 1'b1;
        ST_ACK: if (!req_s) begin
          st_word <= {st_word[15:0], 1'b0};
          if (bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req_s) state_nxt = CMD_ACK;
      CMD_REQ:  if (req_s) state_nxt = CMD_ACK;
      CMD_ACK:  if (!req_s) state_nxt = (bit_cnt == LAST_BIT) ? CHECK : CMD_REQ;
      CHECK:    state_nxt = parity_ok ? DISPATCH : DONE;
      DISPATCH: if (cmd_ready) state_nxt = RSP_WAIT;
      RSP_WAIT: if (rsp_fire) state_nxt = rsp_nodata ? DONE : ST_REQ;
      ST_REQ:   if (req_s) state_nxt = ST_SETUP;
      ST_SETUP: if (setup_cnt == SW'(DATA_SETUP - 1)) state_nxt = ST_ACK;
      ST_ACK:   if (!req_s) state_nxt = (bit_cnt != LAST_BIT) ? ST_REQ :
                                        (last_q ? DONE : RSP_WAIT);
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;
  end

  // Outputs are decoded from the next state so each one leaves a flop.
  always_comb begin
    ack_nxt           = (state_nxt == CMD_ACK) || (state_nxt == ST_ACK);
    cc_nxt            = (state_nxt == IDLE);
    cmd_valid_nxt     = (state_nxt == DISPATCH);
    rsp_ready_nxt     = (state_nxt == RSP_WAIT);
    parity_err_nxt    = (state == CHECK) && !parity_ok;
    frame_timeout_nxt = timeout;

    confstat_nxt = esdi_confstat_data;
    if (state == ST_REQ && req_s) confstat_nxt = st_word[16];
    if (state_nxt == IDLE)        confstat_nxt = 1'b0;

    attention_nxt = esdi_attention;
    if (state == IDLE && req_s) attention_nxt = 1'b0;
    if (parity_err_nxt)         attention_nxt = 1'b1;
    if (state == DONE)          attention_nxt = esdi_attention | rsp_att_q;
    if (timeout)                attention_nxt = 1'b1;
  end

  always_ff @(posedge csr_aclk or posedge csr_areset) begin
    if (csr_areset) begin
      esdi_transfer_ack     <= 1'b0;
      esdi_confstat_data    <= 1'b0;
      esdi_command_complete <= 1'b1;
      esdi_attention        <= 1'b0;
      cmd_valid             <= 1'b0;
      rsp_ready             <= 1'b0;
      parity_err            <= 1'b0;
      frame_timeout         <= 1'b0;
    end else begin
      esdi_transfer_ack     <= ack_nxt;
      esdi_confstat_data    <= confstat_nxt;
      esdi_command_complete <= cc_nxt;
      esdi_attention        <= attention_nxt;
      cmd_valid             <= cmd_valid_nxt;
      rsp_ready             <= rsp_ready_nxt;
      parity_err            <= parity_err_nxt;
      frame_timeout         <= frame_timeout_nxt;
    end
  end

endmodule

// File: tb/tb_esdi_drive_cmd_responder.sv
// tb/tb_esdi_drive_cmd_responder.sv - scoreboard bench for the ESDI drive command responder
module tb_esdi_drive_cmd_responder;

  localparam int DATA_SETUP = 6;

  logic        csr_aclk = 1'b0;
  logic        csr_areset;
  logic        esdi_transfer_req, esdi_command_data;
  logic        esdi_transfer_ack, esdi_confstat_data, esdi_command_complete, esdi_attention;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_data;
  logic        rsp_valid, rsp_ready, rsp_last, rsp_nodata, rsp_attention;
  logic [15:0] rsp_data;
  logic        parity_err, frame_timeout;

  esdi_drive_cmd_responder #(
    .SYNC_STAGES(2), .DATA_SETUP(DATA_SETUP), .BIT_TIMEOUT(100)
  ) dut (
    .csr_aclk(csr_aclk), .csr_areset(csr_areset),
    .esdi_transfer_req(esdi_transfer_req), .esdi_command_data(esdi_command_data),
    .esdi_transfer_ack(esdi_transfer_ack), .esdi_confstat_data(esdi_confstat_data),
    .esdi_command_complete(esdi_command_complete), .esdi_attention(esdi_attention),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_nodata(rsp_nodata), .rsp_attention(rsp_attention),
    .parity_err(parity_err), .frame_timeout(frame_timeout)
  );

  always #5 csr_aclk = ~csr_aclk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge csr_aclk) cyc++;

  logic [15:0] exp_cmd_q[$];
  logic [16:0] exp_st_q[$];
  logic        reading = 1'b0;
  int          n_perr = 0, n_to = 0, n_cmd = 0, to_cyc = 0, last_chg = 0, nb = 0;
  logic [16:0] w_acc = '0;
  logic        ack_q = 1'b0, cs_q = 1'b0, cv_q = 1'b0, cr_q = 1'b0;
  logic [15:0] cd_q = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  // Monitor: pops expected commands/status words when the DUT presents them.
  always @(negedge csr_aclk) begin
    if (csr_areset) begin
      nb = 0;
    end else begin
      if (cmd_valid && cv_q && !cr_q) check("cmd_data_stable", {16'h0, cmd_data}, {16'h0, cd_q});
      if (cmd_valid && cmd_ready) begin
        n_cmd++;
        if (exp_cmd_q.size() == 0) check("unexpected_cmd", {16'h0, cmd_data}, 32'hFFFF_FFFF);
        else check("cmd_data", {16'h0, cmd_data}, {16'h0, exp_cmd_q.pop_front()});
      end
      if (esdi_confstat_data !== cs_q) last_chg = cyc;
      if (reading && esdi_transfer_ack && !ack_q) begin
        check("data_setup_ok", (cyc - last_chg) >= DATA_SETUP, 1);
        w_acc = {w_acc[15:0], esdi_confstat_data};
        nb++;
        if (nb == 17) begin
          nb = 0;
          if (exp_st_q.size() == 0) check("unexpected_status", {15'h0, w_acc}, 32'hFFFF_FFFF);
          else check("status_word", {15'h0, w_acc}, {15'h0, exp_st_q.pop_front()});
        end
      end
      if (parity_err) n_perr++;
      if (frame_timeout) begin
        n_to++;
        to_cyc = cyc;
      end
    end
    ack_q = esdi_transfer_ack;
    cs_q  = esdi_confstat_data;
    cv_q  = cmd_valid;
    cr_q  = cmd_ready;
    cd_q  = cmd_data;
  end

  task automatic wait_ack(input logic v, input string name);
    int n = 0;
    while (esdi_transfer_ack !== v && n < 200) begin
      @(negedge csr_aclk);
      n++;
    end
    if (esdi_transfer_ack !== v) bound_fail(name);
  endtask

  task automatic wait_cc(input string name);
    int n = 0;
    while (esdi_command_complete !== 1'b1 && n < 100) begin
      @(negedge csr_aclk);
      n++;
    end
    if (esdi_command_complete !== 1'b1) bound_fail(name);
  endtask

  task automatic send_bits(input logic [16:0] f, input int first, input int cnt);
    for (int i = first; i < first + cnt; i++) begin
      @(negedge csr_aclk);
      esdi_command_data = f[16 - i];
      @(negedge csr_aclk);
      esdi_transfer_req = 1'b1;
      wait_ack(1'b1, "cmd_ack_rise");
      esdi_transfer_req = 1'b0;
      wait_ack(1'b0, "cmd_ack_fall");
    end
  endtask

  task automatic read_bits(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(negedge csr_aclk);
      esdi_transfer_req = 1'b1;
      wait_ack(1'b1, "st_ack_rise");
      @(negedge csr_aclk);
      esdi_transfer_req = 1'b0;
      wait_ack(1'b0, "st_ack_fall");
    end
  endtask

  task automatic send_rsp(input logic [15:0] d, input logic last, input logic nodata, input logic att);
    int n = 0;
    @(posedge csr_aclk);
    #1;
    rsp_valid = 1'b1; rsp_data = d; rsp_last = last; rsp_nodata = nodata; rsp_attention = att;
    @(negedge csr_aclk);
    while (rsp_ready !== 1'b1 && n < 100) begin
      @(negedge csr_aclk);
      n++;
    end
    if (rsp_ready !== 1'b1) bound_fail("rsp_ready");
    @(posedge csr_aclk);
    #1;
    rsp_valid = 1'b0; rsp_last = 1'b0; rsp_nodata = 1'b0; rsp_attention = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack"}, esdi_transfer_ack, 0);
    check({tag, "_confstat"}, esdi_confstat_data, 0);
    check({tag, "_cc"}, esdi_command_complete, 1);
    check({tag, "_attention"}, esdi_attention, 0);
    check({tag, "_cmd_valid"}, cmd_valid, 0);
    check({tag, "_rsp_ready"}, rsp_ready, 0);
    check({tag, "_pulses"}, {parity_err, frame_timeout}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, c0, t0, n;
    csr_areset = 1'b1;
    esdi_transfer_req = 1'b0; esdi_command_data = 1'b0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    rsp_last = 1'b0; rsp_nodata = 1'b0; rsp_attention = 1'b0;
    repeat (3) @(negedge csr_aclk);
    check_reset_values("reset");
    csr_areset = 1'b0;
    cmd_ready = 1'b1;

    // 0x1234 with good parity, no-data response.
    exp_cmd_q.push_back(16'h1234);
    send_bits({16'h1234, 1'b0}, 0, 1);
    check("cc_low_after_bit0", esdi_command_complete, 0);
    send_bits({16'h1234, 1'b0}, 1, 16);
    send_rsp(16'h0, 1'b1, 1'b1, 1'b0);
    wait_cc("cc_t1");
    check("t1_attention", esdi_attention, 0);

    // 0x1234 with bad parity: no dispatch, attention set.
    n0 = n_perr; c0 = n_cmd;
    send_bits({16'h1234, 1'b1}, 0, 17);
    wait_cc("cc_t2");
    check("t2_parity_err_pulses", n_perr - n0, 1);
    check("t2_no_dispatch", n_cmd - c0, 0);
    check("t2_attention", esdi_attention, 1);

    // 0x0000 with a stalled cmd_ready, then single status word 0xA5A5.
    cmd_ready = 1'b0;
    exp_cmd_q.push_back(16'h0000);
    send_bits({16'h0000, 1'b1}, 0, 17);
    repeat (6) @(negedge csr_aclk);
    check("t3_cmd_valid_held", cmd_valid, 1);
    check("t3_rsp_ready_low_in_dispatch", rsp_ready, 0);
    @(posedge csr_aclk);
    #1 cmd_ready = 1'b1;
    exp_st_q.push_back({16'hA5A5, 1'b1});
    send_rsp(16'hA5A5, 1'b1, 1'b0, 1'b0);
    @(negedge csr_aclk);
    check("t3_rsp_ready_low_after_beat", rsp_ready, 0);
    reading = 1'b1;
    read_bits(17);
    reading = 1'b0;
    wait_cc("cc_t3");
    check("t3_attention", esdi_attention, 0);

    // Three-word response; attention on a non-final beat is ignored.
    exp_cmd_q.push_back(16'h00FF);
    send_bits({16'h00FF, 1'b1}, 0, 17);
    reading = 1'b1;
    exp_st_q.push_back({16'h0001, 1'b0});
    send_rsp(16'h0001, 1'b0, 1'b0, 1'b1);
    read_bits(17);
    check("t4_cc_after_word1", esdi_command_complete, 0);
    exp_st_q.push_back({16'h8000, 1'b0});
    send_rsp(16'h8000, 1'b0, 1'b0, 1'b0);
    read_bits(17);
    check("t4_cc_after_word2", esdi_command_complete, 0);
    exp_st_q.push_back({16'hFFFF, 1'b1});
    send_rsp(16'hFFFF, 1'b1, 1'b0, 1'b0);
    read_bits(17);
    reading = 1'b0;
    wait_cc("cc_t4");
    check("t4_attention", esdi_attention, 0);

    // Host abandons the frame after 8 bits.
    n0 = n_to;
    send_bits({16'h5555, 1'b1}, 0, 8);
    t0 = cyc;
    n = 0;
    while (n_to == n0 && n < 300) begin
      @(negedge csr_aclk);
      n++;
    end
    if (n_to == n0) bound_fail("frame_timeout");
    check("t5_timeout_pulses", n_to - n0, 1);
    check("t5_timeout_latency", (to_cyc - t0 >= 95) && (to_cyc - t0 <= 110), 1);
    @(negedge csr_aclk);
    check("t5_attention", esdi_attention, 1);
    check("t5_cc", esdi_command_complete, 1);
    check("t5_ack", esdi_transfer_ack, 0);

    // Full frame after the timeout, no-data response with attention.
    exp_cmd_q.push_back(16'hBEEF);
    send_bits({16'hBEEF, 1'b0}, 0, 1);
    check("t5b_attention_cleared", esdi_attention, 0);
    send_bits({16'hBEEF, 1'b0}, 1, 16);
    send_rsp(16'h0, 1'b1, 1'b1, 1'b1);
    wait_cc("cc_t5b");
    check("t5b_attention", esdi_attention, 1);

    // Asynchronous reset while status bit 5 is acknowledged.
    exp_cmd_q.push_back(16'h1234);
    send_bits({16'h1234, 1'b0}, 0, 17);
    send_rsp(16'hFFFF, 1'b1, 1'b0, 1'b0);
    read_bits(5);
    @(negedge csr_aclk);
    esdi_transfer_req = 1'b1;
    wait_ack(1'b1, "t6_ack_rise");
    check("t6_ack_before_reset", esdi_transfer_ack, 1);
    #2 csr_areset = 1'b1;
    #1 check_reset_values("midframe_reset");
    esdi_transfer_req = 1'b0;
    @(negedge csr_aclk);
    csr_areset = 1'b0;
    repeat (4) @(negedge csr_aclk);
    check("t6_idle_cc", esdi_command_complete, 1);

    check("cmd_queue_drained", exp_cmd_q.size(), 0);
    check("status_queue_drained", exp_st_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/esdi_drive_cmd_responder.md
# esdi_drive_cmd_responder

Drive-side end of the ESDI serial command channel. It receives 17-bit command frames bit-serially over the Transfer Req/Ack handshake and presents each checked 16-bit command on a valid/ready port to the drive model. It then returns zero or more 17-bit status/configuration words over the same handshake, and drives Command Complete and Attention. It lets the host-side command controller and its firmware run in loopback or simulation without a physical drive.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `esdi_transfer_req` and `esdi_command_data`; minimum 2.
- `DATA_SETUP`, default 6: cycles `esdi_confstat_data` is stable before `esdi_transfer_ack` rises on a status bit (≥50 ns at 100 MHz).
- `BIT_TIMEOUT`, default 1_000_000: cycles allowed between bits inside a frame (10 ms at 100 MHz).
- `csr_aclk` in 1: the single clock.
- `csr_areset` in 1: asynchronous, active-high reset.
- `esdi_transfer_req` in 1: host handshake request, asynchronous to `csr_aclk`.
- `esdi_command_data` in 1: host serial command bit, asynchronous to `csr_aclk`.
- `esdi_transfer_ack` out 1: drive handshake acknowledge.
- `esdi_confstat_data` out 1: serial status/configuration bit.
- `esdi_command_complete` out 1: high when the drive is idle and ready for a command.
- `esdi_attention` out 1: error/attention flag.
- `cmd_valid` out 1, `cmd_ready` in 1: command handoff to the drive model.
- `cmd_data` out 16: received command word.
- `rsp_valid` in 1, `rsp_ready` out 1: response words from the drive model.
- `rsp_data` in 16: status word to serialize.
- `rsp_last` in 1: this is the final word of the response.
- `rsp_nodata` in 1: the response has no data words; `rsp_data` is ignored and the beat is final.
- `rsp_attention` in 1: set Attention at completion; sampled on the final beat.
- `parity_err` out 1: one-cycle pulse when a bad-parity frame is received.
- `frame_timeout` out 1: one-cycle pulse when a frame aborts on timeout.

## Operation
- Frame format: bit 15 first, bit 0, then the parity bit. Parity is odd over all 17 bits. Both directions use the same format.
- Command bit handshake:
  - Wait for synchronized req = 1, then sample synchronized data into the shift register and raise ack.
  - Wait for req = 0, then drop ack.
- Status bit handshake:
  - Wait for req = 1, drive `confstat_data`, and hold it `DATA_SETUP` cycles.
  - Raise ack.
  - Wait for req = 0, drop ack, and keep data stable until ack has dropped.
- FSM states: IDLE, CMD_REQ, CMD_ACK, CHECK, DISPATCH, RSP_WAIT, ST_REQ, ST_SETUP, ST_ACK, DONE.
  - IDLE: `command_complete` = 1. A req rise starts the first command bit.
  - First command bit accepted: `command_complete` → 0 and `attention` → 0.
  - CMD_REQ/CMD_ACK loop 17 times, counted with a 5-bit counter 0..16.
  - CHECK: parity bad → pulse `parity_err`, set `attention`, go to DONE (no dispatch). Parity good → DISPATCH.
  - DISPATCH: hold `cmd_valid` with stable `cmd_data` until `cmd_ready`, then go to RSP_WAIT.
  - RSP_WAIT: `rsp_ready` = 1. A beat with `rsp_nodata` goes to DONE. A data beat loads the 17-bit word with computed parity and goes to ST_REQ.
  - ST_REQ/ST_SETUP/ST_ACK loop 17 bits. After the last bit: if `rsp_last` was set, go to DONE; otherwise return to RSP_WAIT for the next word.
  - DONE: `command_complete` → 1, `attention` |= latched `rsp_attention`, go to IDLE.
- Timeout: while in CMD_REQ/CMD_ACK (after the first bit) or ST_REQ/ST_ACK, count cycles since the last req edge. Reaching `BIT_TIMEOUT` causes:
  - drop ack;
  - pulse `frame_timeout`;
  - set `attention`;
  - `command_complete` → 1;
  - go to IDLE.
- Req already high in IDLE after a timeout: this is treated as a new first bit.

## Timing
- Reset values: ack 0, `confstat_data` 0, `command_complete` 1, `attention` 0, `cmd_valid` 0, `rsp_ready` 0, pulses 0. All counters and the FSM are cleared.
- Reset mid-frame aborts immediately with no pulses. The host side then times out.
- Ack latency after req: SYNC_STAGES+1 cycles for command bits; SYNC_STAGES+1+DATA_SETUP cycles for status bits.
- Ack-drop latency after req falls: SYNC_STAGES+1 cycles.
- `cmd_valid`/`cmd_data` must not change until the handshake completes. `rsp_ready` is high only in RSP_WAIT.
- All outputs are registered, with no combinational paths from ESDI inputs.

## Structure
- Shared package `esdi_pkg`: `ESDI_FRAME_BITS` = 17 and an odd-parity function.
- Sub-module `esdi_sync` (parameterized N-flop synchronizer), instantiated twice.
- The timeout counter width is $clog2(BIT_TIMEOUT+1).

## Test plan
- Host sends 0x1234 with parity 0 → `cmd_data` = 0x1234 with `cmd_valid`; `command_complete` low from bit 1. Model returns `rsp_nodata` → `command_complete` = 1, `attention` = 0.
- Host sends 0x1234 with parity 1 → `parity_err` pulse, no `cmd_valid`, `attention` = 1, `command_complete` = 1.
- Command 0x0000 (parity 1), then response 0xA5A5 with `rsp_last` → host reads 0xA5A5 with parity 1. Each ack rises ≥ `DATA_SETUP` cycles after the data changes.
- Three-word response 0x0001, 0x8000, 0xFFFF (last) → host reads the words in order with parity bits 0, 0, 1. `command_complete` rises only after the third word.
- Host stops after 8 command bits (BIT_TIMEOUT set to 100 for the sim) → `frame_timeout` pulse at 100 cycles, `attention` = 1. A following full frame is received correctly.
- Reset asserted during status bit 5 → all outputs return to reset values within one cycle, asynchronously.
